// File: rtl/ps2_ascii_kbd_pkg.sv
// rtl/ps2_ascii_kbd_pkg.sv - shared constants, receiver states and digit helper for the PS/2 ASCII keyboard
// Contents: set-2 prefix scan codes, ASCII control codes, receiver FSM encoding,
//           shifted-digit lookup used by ps2_scan_to_ascii.
package ps2_ascii_kbd_pkg;

  // Set-2 prefix / modifier scan codes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // ASCII control codes
  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Shifted glyph of digit key d (US layout: 0..9 -> ) ! @ # $ % ^ & * ( )
  function automatic logic [7:0] shifted_digit(input logic [3:0] d);
    case (d)
      4'd0:    shifted_digit = 8'h29;
      4'd1:    shifted_digit = 8'h21;
      4'd2:    shifted_digit = 8'h40;
      4'd3:    shifted_digit = 8'h23;
      4'd4:    shifted_digit = 8'h24;
      4'd5:    shifted_digit = 8'h25;
      4'd6:    shifted_digit = 8'h5E;
      4'd7:    shifted_digit = 8'h26;
      4'd8:    shifted_digit = 8'h2A;
      4'd9:    shifted_digit = 8'h28;
      default: shifted_digit = ASCII_NUL;
    endcase
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// rtl/ps2_scan_to_ascii.sv - combinational set-2 make code to ASCII map
// Ports: i_code  [7:0] make code
//        i_shift       either shift key held
//        o_ascii [7:0] ASCII character, 0x00 when the code is unmapped
module ps2_scan_to_ascii
  import ps2_ascii_kbd_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_shift,
  output logic [7:0] o_ascii
);

  logic [7:0] w_letter;     // lowercase letter, 0 if not a letter key
  logic [3:0] w_digit;
  logic       w_digit_vld;

  always_comb begin
    w_letter = ASCII_NUL;
    case (i_code)
      8'h1C: w_letter = 8'h61; 8'h32: w_letter = 8'h62; 8'h21: w_letter = 8'h63;
      8'h23: w_letter = 8'h64; 8'h24: w_letter = 8'h65; 8'h2B: w_letter = 8'h66;
      8'h34: w_letter = 8'h67; 8'h33: w_letter = 8'h68; 8'h43: w_letter = 8'h69;
      8'h3B: w_letter = 8'h6A; 8'h42: w_letter = 8'h6B; 8'h4B: w_letter = 8'h6C;
      8'h3A: w_letter = 8'h6D; 8'h31: w_letter = 8'h6E; 8'h44: w_letter = 8'h6F;
      8'h4D: w_letter = 8'h70; 8'h15: w_letter = 8'h71; 8'h2D: w_letter = 8'h72;
      8'h1B: w_letter = 8'h73; 8'h2C: w_letter = 8'h74; 8'h3C: w_letter = 8'h75;
      8'h2A: w_letter = 8'h76; 8'h1D: w_letter = 8'h77; 8'h22: w_letter = 8'h78;
      8'h35: w_letter = 8'h79; 8'h1A: w_letter = 8'h7A;
      default: w_letter = ASCII_NUL;
    endcase
  end

  always_comb begin
    w_digit     = 4'd0;
    w_digit_vld = 1'b1;
    case (i_code)
      8'h45: w_digit = 4'd0; 8'h16: w_digit = 4'd1; 8'h1E: w_digit = 4'd2;
      8'h26: w_digit = 4'd3; 8'h25: w_digit = 4'd4; 8'h2E: w_digit = 4'd5;
      8'h36: w_digit = 4'd6; 8'h3D: w_digit = 4'd7; 8'h3E: w_digit = 4'd8;
      8'h46: w_digit = 4'd9;
      default: w_digit_vld = 1'b0;
    endcase
  end

  always_comb begin
    o_ascii = ASCII_NUL;
    if (w_letter != ASCII_NUL) begin
      o_ascii = i_shift ? (w_letter - 8'h20) : w_letter;
    end else if (w_digit_vld) begin
      o_ascii = i_shift ? shifted_digit(w_digit) : (8'h30 + {4'd0, w_digit});
    end else begin
      case (i_code)
        8'h29:   o_ascii = ASCII_SPACE;
        8'h5A:   o_ascii = ASCII_CR;
        8'h66:   o_ascii = ASCII_BS;
        8'h76:   o_ascii = ASCII_ESC;
        8'h0D:   o_ascii = ASCII_TAB;
        default: o_ascii = ASCII_NUL;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_kbd.sv
// rtl/ps2_ascii_kbd.sv - PS/2 keyboard receiver, scan-code decoder and ASCII character FIFO
// Ports: i_clk, i_rst (async, active-high)
//        i_ps2_clk, i_ps2_data   raw asynchronous PS/2 lines
//        o_kbd_data [7:0]        FIFO head, 0x00 when empty
//        o_kbd_int               high while FIFO non-empty
//        i_kbd_int_ack           pops the head when o_kbd_int is high
//        o_kbd_overflow          sticky: character dropped on full FIFO
//        o_kbd_frame_err         one-cycle pulse: bad stop, parity (optional) or timeout
// Option: KBD_PARITY_CHECK_EN enables odd-parity checking of received frames.
module ps2_ascii_kbd
  import ps2_ascii_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_kbd_data,
  output logic       o_kbd_int,
  input  logic       i_kbd_int_ack,
  output logic       o_kbd_overflow,
  output logic       o_kbd_frame_err
);

  localparam int RUN_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------- input conditioning ----------------
  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic             r_filt_clk;
  logic [RUN_W-1:0] r_run;
  logic             w_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_clk <= 1'b1;
      r_run      <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      // Flip the filtered level only after FILTER_LEN consecutive disagreeing samples
      if (r_clk_s2 == r_filt_clk) begin
        r_run <= '0;
      end else if (r_run == RUN_W'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_run      <= '0;
      end else begin
        r_run <= r_run + 1'b1;
      end
    end
  end

  assign w_fall = r_filt_clk & ~r_clk_s2 & (r_run == RUN_W'(FILTER_LEN - 1));

  // ---------------- receiver FSM ----------------
  rx_state_t        r_state, w_state_n;
  logic [7:0]       r_sr, w_sr_n;
  logic [2:0]       r_bit, w_bit_n;
  logic [TMO_W-1:0] r_tmo, w_tmo_n;
  logic [7:0]       r_rx_byte, w_rx_byte_n;
  logic             r_rx_valid, w_rx_valid_n;
  logic             r_frame_err, w_frame_err_n;
  logic             w_par_ok;
`ifdef KBD_PARITY_CHECK_EN
  logic             r_par, w_par_n;
  assign w_par_ok = ^{r_sr, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RX_IDLE;
      r_sr        <= '0;
      r_bit       <= '0;
      r_tmo       <= '0;
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_sr        <= w_sr_n;
      r_bit       <= w_bit_n;
      r_tmo       <= w_tmo_n;
      r_rx_byte   <= w_rx_byte_n;
      r_rx_valid  <= w_rx_valid_n;
      r_frame_err <= w_frame_err_n;
`ifdef KBD_PARITY_CHECK_EN
      r_par       <= w_par_n;
`endif
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_sr_n        = r_sr;
    w_bit_n       = r_bit;
    w_rx_byte_n   = r_rx_byte;
    w_rx_valid_n  = 1'b0;
    w_frame_err_n = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
    w_par_n       = r_par;
`endif
    // Timeout counter only runs inside a frame and saturates at the limit
    if (w_fall || r_state == RX_IDLE)       w_tmo_n = '0;
    else if (r_tmo != TMO_W'(TIMEOUT_CYCLES)) w_tmo_n = r_tmo + 1'b1;
    else                                     w_tmo_n = r_tmo;

    if (r_state != RX_IDLE && !w_fall && r_tmo == TMO_W'(TIMEOUT_CYCLES)) begin
      w_state_n     = RX_IDLE;
      w_frame_err_n = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        RX_IDLE: begin
          if (!r_dat_s2) begin
            w_state_n = RX_DATA;
            w_bit_n   = '0;
          end
        end
        RX_DATA: begin
          w_sr_n  = {r_dat_s2, r_sr[7:1]};
          w_bit_n = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_n = RX_PARITY;
        end
        RX_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
          w_par_n = r_dat_s2;
`endif
          w_state_n = RX_STOP;
        end
        RX_STOP: begin
          if (r_dat_s2 && w_par_ok) begin
            w_rx_byte_n  = r_sr;
            w_rx_valid_n = 1'b1;
          end else begin
            w_frame_err_n = 1'b1;
          end
          w_state_n = RX_IDLE;
        end
        default: w_state_n = RX_IDLE;
      endcase
    end
  end

  assign o_kbd_frame_err = r_frame_err;

  // ---------------- prefix / shift decoder ----------------
  logic       r_brk, r_ext, r_shift_l, r_shift_r;
  logic       r_push;
  logic [7:0] r_push_char;
  logic [7:0] w_map;

  ps2_scan_to_ascii u_map (
    .i_code  (r_rx_byte),
    .i_shift (r_shift_l | r_shift_r),
    .o_ascii (w_map)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_push      <= 1'b0;
      r_push_char <= '0;
    end else begin
      r_push <= 1'b0;
      if (r_rx_valid) begin
        if (r_rx_byte == SC_BREAK) begin
          r_brk <= 1'b1;
        end else if (r_rx_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (r_rx_byte == SC_LSHIFT || r_rx_byte == SC_RSHIFT) begin
          // Extended variants of these codes are fake shifts from the keyboard
          if (!r_ext) begin
            if (r_rx_byte == SC_LSHIFT) r_shift_l <= !r_brk;
            else                        r_shift_r <= !r_brk;
          end
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end else begin
          if (!r_brk && !r_ext && w_map != ASCII_NUL) begin
            r_push      <= 1'b1;
            r_push_char <= w_map;
          end
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end
      end
    end
  end

  // ---------------- character FIFO ----------------
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [CNT_W-1:0] r_count, w_cnt_next;
  logic             r_kbd_int, r_overflow;
  logic [7:0]       r_kbd_data, w_head;
  logic             w_pop, w_full, w_push_ok, w_drop;

  assign w_pop     = r_kbd_int & i_kbd_int_ack;
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_ok = r_push & (~w_full | w_pop);
  assign w_drop    = r_push & w_full & ~w_pop;
  assign w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_comb begin
    case ({w_push_ok, w_pop})
      2'b10:   w_cnt_next = r_count + 1'b1;
      2'b01:   w_cnt_next = r_count - 1'b1;
      default: w_cnt_next = r_count;
    endcase
  end

  // The new head may be the slot written this very cycle, so bypass the memory
  assign w_head = (w_push_ok && w_rd_next == r_wr_ptr) ? r_push_char : r_mem[w_rd_next];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_push_char;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_kbd_int  <= 1'b0;
      r_kbd_data <= ASCII_NUL;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_next;
      if (w_drop) r_overflow <= 1'b1;
      if (w_push_ok || w_pop) begin
        r_kbd_int  <= (w_cnt_next != '0);
        r_kbd_data <= (w_cnt_next != '0) ? w_head : ASCII_NUL;
      end
    end
  end

  assign o_kbd_int      = r_kbd_int;
  assign o_kbd_data     = r_kbd_data;
  assign o_kbd_overflow = r_overflow;

endmodule

// File: tb/tb_ps2_ascii_kbd.sv
// tb/tb_ps2_ascii_kbd.sv - directed self-checking bench for ps2_ascii_kbd
module tb_ps2_ascii_kbd;

  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data, ack;
  logic [7:0] kbd_data;
  logic       kbd_int, kbd_overflow, kbd_frame_err;

  int n_vec  = 0;
  int n_miss = 0;
  int ferr_cnt = 0;
  int ferr_base;
  bit seen_push;

  ps2_ascii_kbd #(
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (8),
    .FIFO_DEPTH     (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ps2_clk       (ps2_clk),
    .i_ps2_data      (ps2_data),
    .o_kbd_data      (kbd_data),
    .o_kbd_int       (kbd_int),
    .i_kbd_int_ack   (ack),
    .o_kbd_overflow  (kbd_overflow),
    .o_kbd_frame_err (kbd_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (kbd_frame_err) ferr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Device drives data while the clock is high, then pulses clock low
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    repeat (30) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ack = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_int",  kbd_int, 0);
    check("rst_data", kbd_data, 8'h00);
    check("rst_ovf",  kbd_overflow, 0);
    check("rst_ferr", kbd_frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single 'a'
    send_frame(8'h1C, 1'b0);
    check("a_int",  kbd_int, 1);
    check("a_data", kbd_data, 8'h61);
    do_ack();
    check("a_pop_int",  kbd_int, 0);
    check("a_pop_data", kbd_data, 8'h00);

    // shift handling: A then a
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("shift_A", kbd_data, 8'h41);
    do_ack();
    check("shift_int2", kbd_int, 1);
    check("shift_a", kbd_data, 8'h61);
    do_ack();
    check("shift_empty", kbd_int, 0);

    // break and extended codes queue nothing
    ferr_base = ferr_cnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("prefix_int",  kbd_int, 0);
    check("prefix_ferr", ferr_cnt - ferr_base, 0);

    // '1' with wrong parity
    ferr_base = ferr_cnt;
    send_frame(8'h16, 1'b1);
`ifdef KBD_PARITY_CHECK_EN
    check("par_ferr", ferr_cnt - ferr_base, 1);
    check("par_int",  kbd_int, 0);
`else
    check("par_ferr", ferr_cnt - ferr_base, 0);
    check("par_int",  kbd_int, 1);
    check("par_data", kbd_data, 8'h31);
    do_ack();
`endif

    // stalled frame times out, next frame still decodes
    ferr_base = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_ferr", ferr_cnt - ferr_base, 1);
    check("tmo_int",  kbd_int, 0);
    send_frame(8'h29, 1'b0);
    check("tmo_space", kbd_data, 8'h20);
    do_ack();
    check("ovf_before", kbd_overflow, 0);

    // overflow: a b c d e without ack
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    send_frame(8'h21, 1'b0);
    send_frame(8'h23, 1'b0);
    check("full_ovf0", kbd_overflow, 0);
    send_frame(8'h24, 1'b0);
    check("ovf_set",  kbd_overflow, 1);
    check("ovf_head", kbd_data, 8'h61);

    // 'f' pushed on a full FIFO with ack held on that cycle
    seen_push = 1'b0;
    fork
      send_frame(8'h2B, 1'b0);
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (dut.r_push) begin
            seen_push = 1'b1;
            break;
          end
        end
        if (seen_push) begin
          ack = 1'b1;
          @(negedge clk);
          ack = 1'b0;
        end
      end
    join
    check("push6_seen", seen_push, 1);
    check("push6_ovf",  kbd_overflow, 1);
    check("drain_b", kbd_data, 8'h62);
    do_ack();
    check("drain_c", kbd_data, 8'h63);
    do_ack();
    check("drain_d", kbd_data, 8'h64);
    do_ack();
    check("drain_f", kbd_data, 8'h66);
    do_ack();
    check("drain_empty", kbd_int, 0);
    check("drain_data0", kbd_data, 8'h00);

    // ack while empty is ignored
    do_ack();
    check("ack_empty", kbd_int, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
